key_debounce_array: RTL

- Parametrised multi-channel successor to the board's single-key debouncer.
- Synchronises and debounces CHANNELS raw push-button inputs with a configurable input polarity.
- Outputs per channel:
  - a clean level;
  - one-cycle press and release pulses;
  - a long-press pulse;
  - an auto-repeat pulse train while the key is held.
- Sits between the board key pins and the game/UI control FSMs.

---
 rtl/key_pkg.sv | 21 ++
 rtl/key_debounce_channel.sv | 153 +++++++++++++++
 rtl/key_debounce_array.sv | 43 ++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared key-input timing constants for the 50 MHz board clock, plus the
// hold-phase state type used by every debounce channel.
package key_pkg;

  localparam int KEY_DEBOUNCE_20MS = 1000000;
  localparam int KEY_LONG_1S       = 50000000;
  localparam int KEY_REPEAT_200MS  = 10000000;
  localparam int KEY_CH_MAX        = 16;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_LONG,
    HS_REPEAT,
    HS_SAT
  } hold_state_t;

  function automatic int key_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop synchroniser, debounce counter, hold timer and the
// registered press/release/long/repeat pulses.
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_20MS,
  parameter int LONG_CYCLES     = KEY_LONG_1S,
  parameter int REPEAT_CYCLES   = KEY_REPEAT_200MS,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(key_max(LONG_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_SAT  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] REP_LAST  =
    (REPEAT_CYCLES > 0) ? HOLD_W'(REPEAT_CYCLES - 1) : '0;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_level;
  logic [DB_W-1:0]   r_db_cnt;
  logic              r_press;
  logic              r_release;
  hold_state_t       r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_long;
  logic              r_repeat;

  logic              w_p;
  logic              w_accept;
  logic              w_level_nx;
  hold_state_t       w_state_nx;
  logic [HOLD_W-1:0] w_hold_nx;
  logic              w_long_nx;
  logic              w_repeat_nx;

  // Sync flops reset to the released pin level so reset itself is no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_p        = r_sync2 ^ ACTIVE_LOW;
  assign w_accept   = (w_p != r_level) && (r_db_cnt == DB_LAST);
  assign w_level_nx = r_level ^ w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level   <= 1'b0;
      r_db_cnt  <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_accept & ~r_level;
      r_release <= w_accept & r_level;
      if (w_p == r_level || w_accept) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      if (w_accept) begin
        r_level <= ~r_level;
      end
    end
  end

  // Hold timer follows the next-cycle level so cycle P starts at count 0 and
  // the release cycle never carries a long/repeat pulse.
  always_comb begin
    w_state_nx  = r_state;
    w_hold_nx   = r_hold;
    w_long_nx   = 1'b0;
    w_repeat_nx = 1'b0;
    if (!w_level_nx) begin
      w_state_nx = HS_IDLE;
      w_hold_nx  = '0;
    end else begin
      case (r_state)
        HS_IDLE: begin
          w_state_nx = HS_LONG;
          w_hold_nx  = '0;
        end
        HS_LONG: begin
          if (r_hold == LONG_LAST) begin
            w_long_nx = 1'b1;
            if (REPEAT_CYCLES > 0) begin
              w_state_nx = HS_REPEAT;
              w_hold_nx  = '0;
            end else begin
              w_state_nx = HS_SAT;
              w_hold_nx  = LONG_SAT;
            end
          end else begin
            w_hold_nx = r_hold + HOLD_W'(1);
          end
        end
        HS_REPEAT: begin
          if (r_hold == REP_LAST) begin
            w_repeat_nx = 1'b1;
            w_hold_nx   = '0;
          end else begin
            w_hold_nx = r_hold + HOLD_W'(1);
          end
        end
        HS_SAT: begin
          w_state_nx = HS_SAT;
        end
        default: begin
          w_state_nx = HS_IDLE;
          w_hold_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HS_IDLE;
      r_hold   <= '0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_hold   <= w_hold_nx;
      r_long   <= w_long_nx;
      r_repeat <= w_repeat_nx;
    end
  end

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;
  assign key_long    = r_long;
  assign key_repeat  = r_repeat;

endmodule

// File: rtl/key_debounce_array.sv
// CHANNELS independent debounced keys with press/release/long/repeat pulses
// and a combined any-key-pressed flag.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_20MS,
  parameter int LONG_CYCLES     = KEY_LONG_1S,
  parameter int REPEAT_CYCLES   = KEY_REPEAT_200MS,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] key_raw,
  output logic [CHANNELS-1:0] key_level,
  output logic [CHANNELS-1:0] key_press,
  output logic [CHANNELS-1:0] key_release,
  output logic [CHANNELS-1:0] key_long,
  output logic [CHANNELS-1:0] key_repeat,
  output logic                any_pressed
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw[g]),
      .key_level   (key_level[g]),
      .key_press   (key_press[g]),
      .key_release (key_release[g]),
      .key_long    (key_long[g]),
      .key_repeat  (key_repeat[g])
    );
  end

  assign any_pressed = |key_level;

endmodule
